cla_pipe_add_sub: RTL and testbench

CLA_PIPE_ADD_SUB -- requirements
Module: cla_pipe_add_sub

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_group.sv | 46 ++++
 rtl/cla_pipe_add_sub.sv | 194 +++++++++++++++++++
 tb/tb_cla_pipe_add_sub.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
// The op encoding matches the sub_i input bit.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_GROUP = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } cla_op_e;

endpackage

// File: rtl/cla_group.sv
// One lookahead group: flat sum-of-products carries into every bit,
// plus group generate/propagate for the next lookahead level.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] g_i,
    input  logic [GROUP-1:0] p_i,
    input  logic             c_i,
    output logic             g_o,
    output logic             p_o,
    output logic [GROUP-1:0] c_o
);

    // Carry into bit n, expanded as c_i&p[0..n-1] | sum of g[i]&p[i+1..n-1].
    function automatic logic lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c,
        input int               n
    );
        logic acc;
        logic term;
        acc = c;
        for (int k = 0; k < n; k++) begin
            acc = acc & p[k];
        end
        for (int i = 0; i < n; i++) begin
            term = g[i];
            for (int k = i + 1; k < n; k++) begin
                term = term & p[k];
            end
            acc = acc | term;
        end
        return acc;
    endfunction

    always_comb begin
        c_o = '0;
        for (int j = 0; j < GROUP; j++) begin
            c_o[j] = lookahead(g_i, p_i, c_i, j);
        end
        g_o = lookahead(g_i, p_i, 1'b0, GROUP);
        p_o = &p_i;
    end

endmodule

// File: rtl/cla_pipe_add_sub.sv
// Two-stage pipelined signed add/subtract built on a two-level carry lookahead,
// with optional saturation and valid/ready flow control on both sides.
module cla_pipe_add_sub
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic                    sub_i,
    input  logic                    sat_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [WIDTH-1:0] result_o,
    output logic                    carry_o,
    output logic                    ovf_o,
    output logic                    zero_o,
    output logic                    neg_o
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < 2 * GROUP) begin : g_bad_param
        $error("cla_pipe_add_sub: WIDTH must be a multiple of GROUP and >= 2*GROUP");
    end

    function automatic logic signed [WIDTH-1:0] saturate(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    function automatic logic span_and(
        input logic [WIDTH-1:0] v,
        input int               lo,
        input int               n
    );
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < n; i++) begin
            acc = acc & v[lo+i];
        end
        return acc;
    endfunction

    // Carry into group n from group G/P terms, flattened across all groups below it.
    function automatic logic group_carry(
        input logic [NG-1:0] gg,
        input logic [NG-1:0] gp,
        input logic          cin,
        input int            n
    );
        logic acc;
        logic term;
        acc = cin;
        for (int k = 0; k < n; k++) begin
            acc = acc & gp[k];
        end
        for (int i = 0; i < n; i++) begin
            term = gg[i];
            for (int k = i + 1; k < n; k++) begin
                term = term & gp[k];
            end
            acc = acc | term;
        end
        return acc;
    endfunction

    logic             sub_op;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c_loc;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;

    assign sub_op = (cla_op_e'(sub_i) == OP_SUB);
    assign bx     = b_i ^ {WIDTH{sub_op}};
    assign g      = a_i & bx;
    assign p      = a_i ^ bx;

    // Group carry-ins are not known yet, so each group resolves its carries
    // assuming zero carry-in; stage 2 ORs in the real group carry.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .g_i (g[k*GROUP +: GROUP]),
            .p_i (p[k*GROUP +: GROUP]),
            .c_i (1'b0),
            .g_o (gg[k]),
            .p_o (gp[k]),
            .c_o (c_loc[k*GROUP +: GROUP])
        );
    end

    // ---- stage 1 boundary ----
    logic             vld_p1;
    logic [WIDTH-1:0] p_p1;
    logic [WIDTH-1:0] c_loc_p1;
    logic [NG-1:0]    gg_p1;
    logic [NG-1:0]    gp_p1;
    logic             a_msb_p1;
    logic             bx_msb_p1;
    logic             sub_p1;
    logic             sat_p1;
    logic             vld_p2;
    logic             adv_p2;

    assign adv_p2     = !vld_p2 || out_ready_i;
    assign in_ready_o = adv_p2 || !vld_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else if (in_ready_o) begin
            vld_p1 <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            p_p1      <= p;
            c_loc_p1  <= c_loc;
            gg_p1     <= gg;
            gp_p1     <= gp;
            a_msb_p1  <= a_i[WIDTH-1];
            bx_msb_p1 <= bx[WIDTH-1];
            sub_p1    <= sub_op;
            sat_p1    <= sat_i;
        end
    end

    logic [NG:0]             c_grp;
    logic [WIDTH-1:0]        cb;
    logic [WIDTH-1:0]        sum;
    logic                    ovf_s2;
    logic signed [WIDTH-1:0] res_s2;

    always_comb begin
        c_grp = '0;
        cb    = '0;
        for (int k = 0; k <= NG; k++) begin
            c_grp[k] = group_carry(gg_p1, gp_p1, sub_p1, k);
        end
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                cb[k*GROUP+j] = c_loc_p1[k*GROUP+j]
                              | (span_and(p_p1, k * GROUP, j) & c_grp[k]);
            end
        end
        sum    = p_p1 ^ cb;
        ovf_s2 = (a_msb_p1 == bx_msb_p1) && (sum[WIDTH-1] != a_msb_p1);
        res_s2 = (sat_p1 && ovf_s2) ? saturate(a_msb_p1) : sum;
    end

    // ---- stage 2 boundary ----
    logic signed [WIDTH-1:0] result_p2;
    logic                    carry_p2;
    logic                    ovf_p2;
    logic                    zero_p2;
    logic                    neg_p2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            carry_p2  <= 1'b0;
            ovf_p2    <= 1'b0;
            zero_p2   <= 1'b0;
            neg_p2    <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= res_s2;
                carry_p2  <= c_grp[NG];
                ovf_p2    <= ovf_s2;
                zero_p2   <= ~|res_s2;
                neg_p2    <= res_s2[WIDTH-1];
            end
        end
    end

    assign out_valid_o = vld_p2;
    assign result_o    = result_p2;
    assign carry_o     = carry_p2;
    assign ovf_o       = ovf_p2;
    assign zero_o      = zero_p2;
    assign neg_o       = neg_p2;

endmodule

// File: tb/tb_cla_pipe_add_sub.sv
// Scoreboard bench for cla_pipe_add_sub at WIDTH=16, GROUP=4.
module tb_cla_pipe_add_sub;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               sub;
    logic               sat;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] result;
    logic               carry;
    logic               ovf;
    logic               zero;
    logic               neg;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    cla_pipe_add_sub #(
        .WIDTH (16),
        .GROUP (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .sat_i       (sat),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .carry_o     (carry),
        .ovf_o       (ovf),
        .zero_o      (zero),
        .neg_o       (neg)
    );

    // Golden model from plain signed/unsigned arithmetic.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic ms, input logic mt);
        exp_t        e;
        logic [16:0] u;
        logic [15:0] bx;
        int          sa;
        int          sb;
        int          sr;
        bx  = ms ? ~mb : mb;
        u   = {1'b0, ma} + {1'b0, bx} + {16'd0, ms};
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        sr  = ms ? sa - sb : sa + sb;
        e.v = (sr > 32767) || (sr < -32768);
        e.c = u[16];
        if (mt && e.v) e.res = (sr > 0) ? 16'h7FFF : 16'h8000;
        else           e.res = u[15:0];
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got res=%h c=%b v=%b z=%b n=%b, expected no beat",
                         result, carry, ovf, zero, neg);
            end else begin
                mon_e = exp_q.pop_front();
                if ({result, carry, ovf, zero, neg} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_out: got res=%h c=%b v=%b z=%b n=%b, expected res=%h c=%b v=%b z=%b n=%b",
                             result, carry, ovf, zero, neg,
                             mon_e.res, mon_e.c, mon_e.v, mon_e.z, mon_e.n);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [15:0] ta, input logic [15:0] tb,
                             input logic ts, input logic tt, input exp_t e);
        int n;
        bit done;
        a        = ta;
        b        = tb;
        sub      = ts;
        sat      = tt;
        in_valid = 1'b1;
        n        = 0;
        done     = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
        end
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (exp_q.size() == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        sat       = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL rst_result: got %h, expected 0000", result);
        end
        checks++;
        if ({carry, ovf, zero, neg} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_flags: got %b, expected 0000", {carry, ovf, zero, neg});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b, expected 1", in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        bit ok;
        out_ready = 1'b1;
        a         = 16'h0005;
        b         = 16'h0003;
        sub       = 1'b0;
        sat       = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_in_ready: got %b, expected 1", in_ready);
        end
        exp_q.push_back('{res: 16'h0008, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle1: got out_valid=%b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_cycle2: got out_valid=%b, expected 1", out_valid);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lat_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_directed;
        bit ok;
        out_ready = 1'b1;
        send_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{res: 16'h8000, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1});
        send_beat(16'h7FFF, 16'h0001, 1'b0, 1'b1, '{res: 16'h7FFF, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b0});
        send_beat(16'h1234, 16'hEDCC, 1'b0, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
        send_beat(16'h0000, 16'h0001, 1'b1, 1'b0, '{res: 16'hFFFF, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
        send_beat(16'h8000, 16'h0001, 1'b1, 1'b1, '{res: 16'h8000, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b1});
        send_beat(16'h8000, 16'h0001, 1'b1, 1'b0, '{res: 16'h7FFF, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b0});
        send_beat(16'h0000, 16'h8000, 1'b1, 1'b1, '{res: 16'h7FFF, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b0});
        send_beat(16'h0005, 16'h0005, 1'b1, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dir_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit          ok;
        time         t0;
        logic [15:0] ta;
        logic [15:0] tb;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            ta = 16'(i * 16'h1357 + 16'h0F0F);
            tb = 16'(16'hFFFF - i * 16'h2222);
            send_beat(ta, tb, 1'(i % 2), 1'(i / 4), model(ta, tb, 1'(i % 2), 1'(i / 4)));
        end
        checks++;
        if (($time - t0) != 80) begin
            errors++;
            $display("FAIL b2b_rate: got %0t time units for 8 beats, expected 80", $time - t0);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic        sv [3];
        logic        tv [3];
        exp_t        ev [3];
        logic [19:0] snap;
        int          acc;
        int          n;
        bit          ok;
        av[0] = 16'h0001; bv[0] = 16'h0002; sv[0] = 1'b0; tv[0] = 1'b0;
        ev[0] = '{res: 16'h0003, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
        av[1] = 16'h0100; bv[1] = 16'h0001; sv[1] = 1'b1; tv[1] = 1'b0;
        ev[1] = '{res: 16'h00FF, c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0};
        av[2] = 16'h7000; bv[2] = 16'h7000; sv[2] = 1'b0; tv[2] = 1'b1;
        ev[2] = '{res: 16'h7FFF, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b0};
        acc  = 0;
        snap = '0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (acc < 3) begin
                a = av[acc]; b = bv[acc]; sub = sv[acc]; sat = tv[acc];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 3) snap = {result, carry, ovf, zero, neg};
            if (in_valid && in_ready) begin
                exp_q.push_back(ev[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d beats accepted, expected 2", acc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b, expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_out_valid: got %b, expected 1", out_valid);
        end
        checks++;
        if ({result, carry, ovf, zero, neg} !== snap) begin
            errors++;
            $display("FAIL bp_hold: got %h, expected %h", {result, carry, ovf, zero, neg}, snap);
        end
        checks++;
        if (result !== 16'h0003) begin
            errors++;
            $display("FAIL bp_head: got %h, expected 0003", result);
        end
        out_ready = 1'b1;
        n = 0;
        while (acc < 3 && n < 20) begin
            a = av[acc]; b = bv[acc]; sub = sv[acc]; sat = tv[acc];
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ev[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || acc != 3) begin
            errors++;
            $display("FAIL bp_drain: got %0d pending and %0d accepted, expected 0 and 3", exp_q.size(), acc);
        end
    endtask

    task automatic test_reset_midflight;
        int stale;
        bit ok;
        out_ready = 1'b0;
        send_beat(16'h0011, 16'h0022, 1'b0, 1'b0, '{res: 16'h0033, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
        send_beat(16'h0044, 16'h0011, 1'b1, 1'b0, '{res: 16'h0033, c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mrst_out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL mrst_result: got %h, expected 0000", result);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mrst_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mrst_stale: got %0d stale cycles, expected 0", stale);
        end
        @(posedge clk);
        #1;
        send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{res: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mrst_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_random;
        int          sent;
        int          cyc;
        bit          pend;
        bit          ok;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rt;
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        ra = '0; rb = '0; rs = 1'b0; rt = 1'b0;
        while (sent < 300 && cyc < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if ($urandom_range(0, 4) != 0) begin
                    case ($urandom_range(0, 5))
                        0:       ra = 16'h7FFF;
                        1:       ra = 16'h8000;
                        default: ra = 16'($urandom);
                    endcase
                    case ($urandom_range(0, 5))
                        0:       rb = 16'h8000;
                        1:       rb = 16'h0001;
                        default: rb = 16'($urandom);
                    endcase
                    rs = 1'($urandom);
                    rt = 1'($urandom);
                    a = ra; b = rb; sub = rs; sat = rt;
                    in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ra, rb, rs, rt));
                sent++;
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 300) begin
            errors++;
            $display("FAIL rnd_sent: got %0d beats accepted, expected 300", sent);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rnd_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
